// File: rtl/axist_patgen_ctrl.sv
// axist_patgen_ctrl
//
// Burst sequencer for the AXIST incrementing pattern generator. A start pulse
// latches the test configuration. The block then issues one gen_ena load pulse
// per burst and counts accepted beats to find the end of each burst. Between
// bursts it can insert an optional idle gap, and it advances the seed by a
// stride after every burst. When cfg_bursts is 0 the run is continuous:
// gen_cont_en is held high and the run lasts until stop.
//
// Handshake: a beat counts only when gen_beat=1 and fifo_full=0 in the same
// cycle, and only while a burst is running. Beats seen in the load or gap
// cycles are ignored. stop has priority over a beat in the same cycle.
//
// Optional feature (macro AXIST_PATCTRL_STALL_CNT_EN): when the macro is
// defined, stall_cnt counts the cycles spent running with fifo_full=1. The
// count saturates at 0xFFFF and is cleared by start. When the macro is
// undefined, stall_cnt is tied to 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, stop       begin sequence (IDLE only) / abort or end continuous run
//   cfg_seed/len/bursts/gap/stride   test configuration, latched on start
//   gen_beat, fifo_full              generator beat and checker back-pressure
//   gen_ena, gen_seed, gen_cnt, gen_cont_en   generator controls
//   busy, done, burst_idx, stall_cnt          status
module axist_patgen_ctrl #(
  parameter int LEADER_MODE = 1,
  parameter int GAP_W       = 8,
  localparam int SW         = 40 * LEADER_MODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [SW-1:0]    cfg_seed,
  input  logic [8:0]       cfg_len,
  input  logic [7:0]       cfg_bursts,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [SW-1:0]    cfg_stride,
  input  logic             gen_beat,
  input  logic             fifo_full,
  output logic             gen_ena,
  output logic [SW-1:0]    gen_seed,
  output logic [8:0]       gen_cnt,
  output logic             gen_cont_en,
  output logic             busy,
  output logic             done,
  output logic [7:0]       burst_idx,
  output logic [15:0]      stall_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [SW-1:0]    seed_r;
  logic [SW-1:0]    stride_r;
  logic [SW-1:0]    gen_seed_r;
  logic [8:0]       len_r;
  logic [7:0]       bursts_r;
  logic [GAP_W-1:0] gap_r;
  logic [GAP_W-1:0] gap_cnt;
  logic [8:0]       beat_cnt;
  logic [7:0]       burst_idx_r;

  logic valid_beat;
  logic cont_mode;
  logic beat_last;

  assign valid_beat = gen_beat & ~fifo_full;
  assign cont_mode  = (bursts_r == 8'd0);
  assign beat_last  = valid_beat && (beat_cnt == len_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      seed_r      <= '0;
      stride_r    <= '0;
      gen_seed_r  <= '0;
      len_r       <= '0;
      bursts_r    <= '0;
      gap_r       <= '0;
      gap_cnt     <= '0;
      beat_cnt    <= '0;
      burst_idx_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            seed_r      <= cfg_seed;
            stride_r    <= cfg_stride;
            len_r       <= cfg_len;
            bursts_r    <= cfg_bursts;
            gap_r       <= cfg_gap;
            gen_seed_r  <= cfg_seed;
            burst_idx_r <= 8'd0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          beat_cnt <= 9'd0;
          state    <= stop ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state <= S_DONE;
          end else if (valid_beat) begin
            if (!beat_last) begin
              beat_cnt <= beat_cnt + 9'd1;
            end else if (cont_mode) begin
              // Continuous: wrap the beat count, keep the same seed.
              beat_cnt    <= 9'd0;
              burst_idx_r <= burst_idx_r + 8'd1;
            end else begin
              burst_idx_r <= burst_idx_r + 8'd1;
              seed_r      <= seed_r + stride_r;
              if (burst_idx_r + 8'd1 == bursts_r) begin
                state <= S_DONE;
              end else if (gap_r == '0) begin
                // Straight back to LOAD, so present the advanced seed now.
                gen_seed_r <= seed_r + stride_r;
                state      <= S_LOAD;
              end else begin
                gap_cnt <= gap_r;
                state   <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (stop) begin
            state <= S_DONE;
          end else if (gap_cnt == GAP_W'(1)) begin
            // seed_r was already advanced at the end of the previous burst.
            gen_seed_r <= seed_r;
            state      <= S_LOAD;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AXIST_PATCTRL_STALL_CNT_EN
  logic [15:0] stall_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= 16'd0;
    end else if (state == S_IDLE && start) begin
      stall_r <= 16'd0;
    end else if (state == S_RUN && fifo_full && stall_r != 16'hFFFF) begin
      stall_r <= stall_r + 16'd1;
    end
  end

  assign stall_cnt = stall_r;
`else
  assign stall_cnt = 16'd0;
`endif

  // LOAD lasts one cycle and is always followed by RUN or DONE, so gen_ena
  // can never be high in two consecutive cycles.
  assign gen_ena     = (state == S_LOAD);
  assign gen_cont_en = cont_mode && (state == S_LOAD || state == S_RUN);
  assign gen_seed    = gen_seed_r;
  assign gen_cnt     = len_r;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign burst_idx   = burst_idx_r;

endmodule
